// File: rtl/ncl_seq_pkg.sv
// Shared types and dual-rail helpers for the NCL adder sequencer.
// All rail helpers work on one {rail1, rail0} pair.
package ncl_seq_pkg;

  typedef enum logic [2:0] {INIT, IDLE, DATA, NULLW, RESP, ERR} seq_state_t;

  function automatic logic [1:0] dr_encode(input logic b);
    return {b, ~b};
  endfunction

  function automatic logic dr_decode(input logic [1:0] r);
    return r[1];
  endfunction

  function automatic logic dr_complete(input logic [1:0] r);
    return r[1] ^ r[0];
  endfunction

  function automatic logic dr_null(input logic [1:0] r);
    return (r == 2'b00);
  endfunction

  function automatic logic dr_illegal(input logic [1:0] r);
    return &r;
  endfunction

endpackage

// File: rtl/ncl_adder_sequencer_if.sv
// Request/response handshake bundle between clocked logic and the sequencer.
interface ncl_adder_sequencer_if #(parameter int WIDTH = 8);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err
  );
endinterface

// File: rtl/ncl_sync.sv
// Single-bit flop-chain synchronizer, cleared to 0 (NULL) by init_n.
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic init_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) chain <= '0;
    else         chain <= STAGES'({chain, d});
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/ncl_adder_sequencer.sv
// Clocked bridge driving a dual-rail NCL ripple adder: encodes operands,
// alternates DATA/NULL wavefronts, closes the sink handshake and returns the sum.
//
// state | meaning
// INIT  | dr_init asserted for INIT_CYCLES after reset release
// IDLE  | inputs NULL, req_ready high
// DATA  | DATA wavefront driven, waiting for ack and complete outputs
// NULLW | NULL wavefront driven, waiting for ack low and all rails low
// RESP  | rsp_valid high until rsp_ready
// ERR   | timeout/illegal code: NULL driven, dr_init pulsed
module ncl_adder_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int INIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  init_n,
  ncl_adder_sequencer_if.slave  req,
  output logic [2*WIDTH-1:0]    dr_a,
  output logic [2*WIDTH-1:0]    dr_b,
  output logic [1:0]            dr_cin,
  output logic                  dr_init,
  input  logic                  ack_in,
  input  logic [2*WIDTH-1:0]    res_sum,
  input  logic [1:0]            res_cout,
  output logic                  res_comp
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int NR = 2 * WIDTH + 2;

  seq_state_t      state;
  logic [TW-1:0]   tcnt;
  logic [IW-1:0]   icnt;
  logic [NR-1:0]   rails_raw, rails_s;
  logic            ack_s;
  logic            all_comp, all_null, any_ill;
  logic [WIDTH:0]  dec;
  logic            phase_done, phase_fail;

  assign rails_raw = {res_cout, res_sum};

  for (genvar g = 0; g < NR; g++) begin : g_rail_sync
    ncl_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .init_n(init_n), .d(rails_raw[g]), .q(rails_s[g])
    );
  end

  ncl_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(clk), .init_n(init_n), .d(ack_in), .q(ack_s)
  );

  function automatic logic [2*WIDTH-1:0] enc_vec(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) enc_vec[2*i +: 2] = dr_encode(v[i]);
  endfunction

  // Carry-out is treated as pair WIDTH so sum and carry share one scan.
  always_comb begin
    all_comp = 1'b1;
    all_null = 1'b1;
    any_ill  = 1'b0;
    dec      = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      all_comp = all_comp & dr_complete(rails_s[2*i +: 2]);
      all_null = all_null & dr_null(rails_s[2*i +: 2]);
      any_ill  = any_ill  | dr_illegal(rails_s[2*i +: 2]);
      dec[i]   = dr_decode(rails_s[2*i +: 2]);
    end
  end

  assign phase_done = (state == DATA) ? (ack_s && all_comp) : (!ack_s && all_null);
  assign phase_fail = ((state == DATA) || (state == NULLW)) &&
                      (any_ill || ((tcnt == '0) && !phase_done));

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state         <= INIT;
      tcnt          <= '0;
      icnt          <= IW'(INIT_CYCLES - 1);
      dr_a          <= '0;
      dr_b          <= '0;
      dr_cin        <= '0;
      dr_init       <= 1'b1;
      res_comp      <= 1'b0;
      req.req_ready <= 1'b0;
      req.rsp_valid <= 1'b0;
      req.rsp_sum   <= '0;
      req.rsp_cout  <= 1'b0;
      req.rsp_err   <= 1'b0;
    end else if (phase_fail) begin
      state        <= ERR;
      dr_a         <= '0;
      dr_b         <= '0;
      dr_cin       <= '0;
      res_comp     <= 1'b0;
      dr_init      <= 1'b1;
      icnt         <= IW'(INIT_CYCLES - 1);
      req.rsp_sum  <= '0;
      req.rsp_cout <= 1'b0;
      req.rsp_err  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (icnt == '0) begin
            dr_init       <= 1'b0;
            req.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            icnt <= icnt - 1'b1;
          end
        end
        IDLE: begin
          if (req.req_valid) begin
            dr_a          <= enc_vec(req.req_a);
            dr_b          <= enc_vec(req.req_b);
            dr_cin        <= dr_encode(req.req_cin);
            req.req_ready <= 1'b0;
            tcnt          <= TW'(TIMEOUT - 1);
            state         <= DATA;
          end
        end
        DATA: begin
          if (phase_done) begin
            req.rsp_sum  <= dec[WIDTH-1:0];
            req.rsp_cout <= dec[WIDTH];
            req.rsp_err  <= 1'b0;
            res_comp     <= 1'b1;
            dr_a         <= '0;
            dr_b         <= '0;
            dr_cin       <= '0;
            tcnt         <= TW'(TIMEOUT - 1);
            state        <= NULLW;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        NULLW: begin
          if (phase_done) begin
            res_comp      <= 1'b0;
            req.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        RESP: begin
          if (req.rsp_ready) begin
            req.rsp_valid <= 1'b0;
            req.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        ERR: begin
          if (icnt == '0) begin
            dr_init       <= 1'b0;
            req.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            icnt <= icnt - 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ncl_adder_sequencer.sv
// Directed + randomized bench for ncl_adder_sequencer with a behavioural
// dual-rail adder responder and an arithmetic reference for the sum.
module tb_ncl_adder_sequencer;
  localparam int W  = 8;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          init_n;
  logic [2*W-1:0] dr_a, dr_b;
  logic [1:0]    dr_cin;
  logic          dr_init;
  logic          ack_in;
  logic [2*W-1:0] res_sum;
  logic [1:0]    res_cout;
  logic          res_comp;

  int checks   = 0;
  int failures = 0;
  logic hang   = 1'b0;
  logic inj    = 1'b0;

  ncl_adder_sequencer_if #(.WIDTH(W)) rq ();

  ncl_adder_sequencer #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TO), .INIT_CYCLES(4)) dut (
    .clk(clk), .init_n(init_n), .req(rq),
    .dr_a(dr_a), .dr_b(dr_b), .dr_cin(dr_cin), .dr_init(dr_init),
    .ack_in(ack_in), .res_sum(res_sum), .res_cout(res_cout), .res_comp(res_comp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  function automatic logic pairs_data(input logic [2*W+5:0] v);
    for (int i = 0; i < W + 3; i++) if (v[2*i+1] == v[2*i]) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural adder: after a random delay, answers a full DATA wavefront
  // with the arithmetic sum, and a NULL wavefront with NULL.
  initial begin : adder_model
    int dly;
    logic [W-1:0] a, b;
    logic [W:0] s;
    dly = 0;
    ack_in = 1'b0; res_sum = '0; res_cout = '0;
    forever begin
      @(negedge clk);
      if (!init_n || dr_init) begin
        ack_in = 1'b0; res_sum = '0; res_cout = '0; dly = 0;
      end else if (pairs_data({dr_a, dr_b, dr_cin}) && !res_comp && !hang && !ack_in) begin
        if (dly == 0) begin
          for (int i = 0; i < W; i++) begin a[i] = dr_a[2*i+1]; b[i] = dr_b[2*i+1]; end
          s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, dr_cin[1]};
          res_sum  = enc(s[W-1:0]);
          res_cout = {s[W], ~s[W]};
          if (inj) res_sum[7:6] = 2'b11;
          ack_in = 1'b1;
        end else dly--;
      end else if ({dr_a, dr_b, dr_cin} == '0 && ack_in) begin
        if (dly == 0) begin
          ack_in = 1'b0; res_sum = '0; res_cout = '0;
        end else dly--;
      end else begin
        dly = $urandom_range(0, 3);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input logic exp_err, input string tag, output int lat);
    logic [W:0] s;
    int n;
    logic saw_comp, saw_init;
    s = exp_err ? '0 : ({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
    n = 0;
    while (!rq.req_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_req_ready"}, 32'(rq.req_ready), 32'd1);
    rq.req_valid = 1'b1; rq.req_a = a; rq.req_b = b; rq.req_cin = cin;
    @(negedge clk);
    rq.req_valid = 1'b0;
    chk({tag, "_dr_a"}, 32'(dr_a), 32'(enc(a)));
    chk({tag, "_dr_b"}, 32'(dr_b), 32'(enc(b)));
    chk({tag, "_dr_cin"}, 32'(dr_cin), {30'd0, cin, ~cin});
    chk({tag, "_busy"}, 32'(rq.req_ready), 32'd0);
    n = 0; saw_comp = 1'b0; saw_init = 1'b0;
    while (!rq.rsp_valid && n < 600) begin
      @(negedge clk); n++;
      saw_comp |= res_comp; saw_init |= dr_init;
    end
    lat = n;
    chk({tag, "_rsp_valid"}, 32'(rq.rsp_valid), 32'd1);
    chk({tag, "_sum"}, 32'(rq.rsp_sum), 32'(s[W-1:0]));
    chk({tag, "_cout"}, 32'(rq.rsp_cout), 32'(s[W]));
    chk({tag, "_err"}, 32'(rq.rsp_err), 32'(exp_err));
    chk({tag, "_comp_pulse"}, 32'(saw_comp), 32'(!exp_err));
    chk({tag, "_init_pulse"}, 32'(saw_init), 32'(exp_err));
    chk({tag, "_comp_low"}, 32'(res_comp), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rq.rsp_valid), 32'd1);
      chk({tag, "_hold_sum"}, 32'({rq.rsp_err, rq.rsp_cout, rq.rsp_sum}),
          32'({exp_err, s}));
      chk({tag, "_hold_busy"}, 32'(rq.req_ready), 32'd0);
    end
    rq.rsp_ready = 1'b1;
    @(negedge clk);
    rq.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rq.rsp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(rq.req_ready), 32'd1);
  endtask

  initial begin
    int lat, n;
    logic [W-1:0] ra, rb;
    init_n = 1'b0;
    rq.req_valid = 1'b0; rq.req_a = '0; rq.req_b = '0; rq.req_cin = 1'b0; rq.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dr_init", 32'(dr_init), 32'd1);
    chk("rst_ready", 32'(rq.req_ready), 32'd0);
    chk("rst_rails", 32'({dr_a, dr_b}), 32'd0);
    chk("rst_misc", 32'({dr_cin, res_comp, rq.rsp_valid, rq.rsp_err}), 32'd0);

    init_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("init_hold", 32'(dr_init), 32'd1);
    end
    @(negedge clk);
    chk("init_done", 32'(dr_init), 32'd0);
    chk("init_ready", 32'(rq.req_ready), 32'd1);
    chk("init_null", 32'({dr_a, dr_b, dr_cin}), 32'd0);

    rq.req_valid = 1'b1; rq.req_a = 8'h5A; rq.req_b = 8'h3C; rq.req_cin = 1'b0;
    @(negedge clk);
    rq.req_valid = 1'b0;
    chk("basic_enc_5a", 32'(dr_a), 32'h6699);
    n = 0;
    while (!rq.rsp_valid && n < 600) begin @(negedge clk); n++; end
    chk("basic_sum", 32'({rq.rsp_err, rq.rsp_cout, rq.rsp_sum}), 32'h096);
    rq.rsp_ready = 1'b1; @(negedge clk); rq.rsp_ready = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 10, 1'b0, "basic", lat);
    chk("basic_latency_min", 32'(lat >= 7), 32'd1);
    run_op(8'hFF, 8'h01, 1'b1, 2, 1'b0, "ovf", lat);
    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0, "zero", lat);

    hang = 1'b1;
    run_op(8'h12, 8'h34, 1'b1, 1, 1'b1, "timeout", lat);
    chk("timeout_window", 32'(lat >= TO && lat <= TO + 12), 32'd1);
    hang = 1'b0;

    inj = 1'b1;
    run_op(8'h0F, 8'h01, 1'b0, 1, 1'b1, "illegal", lat);
    inj = 1'b0;
    run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0, "after_illegal", lat);

    for (int r = 0; r < 6; r++) begin
      ra = W'($urandom); rb = W'($urandom);
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'b0, "rand", lat);
    end

    n = 0;
    while (!rq.req_ready && n < 100) begin @(negedge clk); n++; end
    rq.req_valid = 1'b1; rq.req_a = 8'hA5; rq.req_b = 8'h11; rq.req_cin = 1'b0;
    @(negedge clk);
    rq.req_valid = 1'b0;
    n = 0;
    while (!res_comp && n < 100) begin @(negedge clk); n++; end
    chk("midrst_reached_nullw", 32'(res_comp), 32'd1);
    init_n = 1'b0;
    #1;
    chk("midrst_dr_init", 32'(dr_init), 32'd1);
    chk("midrst_comp", 32'(res_comp), 32'd0);
    chk("midrst_outs", 32'({rq.req_ready, rq.rsp_valid, rq.rsp_err, rq.rsp_cout, rq.rsp_sum}), 32'd0);
    chk("midrst_rails", 32'({dr_a, dr_b}), 32'd0);
    @(negedge clk);
    init_n = 1'b1;
    run_op(8'h80, 8'h80, 1'b1, 1, 1'b0, "post_rst", lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
